dequant_zigzag: RTL

- Entropy-decoder-side stage directly upstream of the 8x8 inverse DCT.
- Accepts one quantized coefficient per handshake, in zigzag scan order.
- Multiplies each coefficient by the quantization table and writes it into an 8x8 coefficient buffer in natural row-major order.
- When the block is complete, pulses idct_start and serves 176-bit rows to the iDCT until it signals done.

---
 rtl/dct_pkg.sv | 31 +++
 rtl/dequant_zigzag_if.sv | 24 ++
 rtl/coef_buffer.sv | 35 +++
 rtl/dequant_zigzag.sv | 84 ++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - widths, zigzag map, luminance quant table and FSM states
package dct_pkg;

  localparam int COEF_W = 12;
  localparam int Q_W    = 8;
  localparam int OUT_W  = 22;
  localparam int ROW_W  = 8 * OUT_W;
  localparam int PROD_W = COEF_W + Q_W + 1;

  typedef enum logic [1:0] {FILL, ZFILL, START, WAIT} state_e;

  // Zigzag scan index -> natural row-major position
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [Q_W-1:0] QTABLE [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

endpackage

// File: rtl/dequant_zigzag_if.sv
// rtl/dequant_zigzag_if.sv - coefficient handshake and iDCT-side read interface
interface dequant_zigzag_if;

  logic signed [dct_pkg::COEF_W-1:0] coef_in;
  logic                              coef_valid;
  logic                              coef_eob;
  logic                              coef_ready;
  logic                              idct_start;
  logic                              idct_done;
  logic [2:0]                        rd_row;
  logic [dct_pkg::ROW_W-1:0]         rd_data;
  logic                              busy;

  modport master (
    output coef_in, coef_valid, coef_eob, idct_done, rd_row,
    input  coef_ready, idct_start, rd_data, busy
  );

  modport slave (
    input  coef_in, coef_valid, coef_eob, idct_done, rd_row,
    output coef_ready, idct_start, rd_data, busy
  );

endinterface

// File: rtl/coef_buffer.sv
// rtl/coef_buffer.sv - 8x8 element store, single-element write, registered row read
module coef_buffer
  import dct_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [2:0]       wr_row,
  input  logic [2:0]       wr_col,
  input  logic [OUT_W-1:0] wr_data,
  input  logic [2:0]       rd_row,
  output logic [ROW_W-1:0] rd_data
);

  logic [OUT_W-1:0] mem_q [8][8];
  logic [ROW_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wen) mem_q[wr_row][wr_col] <= wr_data;
  end

  // Read samples the array before this edge's write lands, so a colliding read sees old data
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < 8; c++) rd_data_d[c*OUT_W +: OUT_W] = mem_q[rd_row][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dequant_zigzag.sv
// rtl/dequant_zigzag.sv - dequantise zigzag coefficients into a natural-order 8x8 block
module dequant_zigzag
  import dct_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  dequant_zigzag_if.slave  bus
);

  state_e              state_q, state_d;
  logic [5:0]          k_q, k_d;
  logic [5:0]          pos;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]    elem;
  logic [OUT_W-1:0]    wdata;
  logic                wen;

  always_comb begin
    pos  = ZZ[k_q];
    prod = PROD_W'(bus.coef_in) * PROD_W'($signed({1'b0, QTABLE[pos]}));
    elem = OUT_W'(prod);
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    wen            = 1'b0;
    wdata          = '0;
    bus.coef_ready = 1'b0;
    bus.idct_start = 1'b0;
    bus.busy       = 1'b0;
    case (state_q)
      FILL: begin
        bus.coef_ready = 1'b1;
        if (bus.coef_valid) begin
          wen   = 1'b1;
          wdata = elem;
          k_d   = k_q + 6'd1;
          if (k_q == 6'd63)      state_d = START;
          else if (bus.coef_eob) state_d = ZFILL;
        end
      end
      ZFILL: begin
        bus.busy = 1'b1;
        wen      = 1'b1;
        k_d      = k_q + 6'd1;
        if (k_q == 6'd63) state_d = START;
      end
      START: begin
        bus.busy       = 1'b1;
        bus.idct_start = 1'b1;
        k_d            = '0;
        state_d        = WAIT;
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (bus.idct_done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  coef_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (wen),
    .wr_row  (pos[5:3]),
    .wr_col  (pos[2:0]),
    .wr_data (wdata),
    .rd_row  (bus.rd_row),
    .rd_data (bus.rd_data)
  );

endmodule
